// File: rtl/id_stage_fwd_pkg.sv
// id_stage_fwd_pkg: shared decode constants, select encodings and the ID->EX bundle.
package id_stage_fwd_pkg;
    localparam int FWD_WB = 2;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] F_JR       = 6'h08;
    localparam logic [5:0] F_JALR     = 6'h09;
    localparam logic [5:0] F_ADDU     = 6'h21;
    localparam logic [5:0] F_SUBU     = 6'h23;
    localparam logic [5:0] F_AND      = 6'h24;
    localparam logic [5:0] F_OR       = 6'h25;
    localparam logic [5:0] F_SLT      = 6'h2a;
    localparam logic [4:0] RI_BLTZ    = 5'b00000;
    localparam logic [4:0] RI_BGEZ    = 5'b00001;
    localparam logic [4:0] RI_BLTZAL  = 5'b10000;
    localparam logic [4:0] RI_BGEZAL  = 5'b10001;
    localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_AND = 4, ALU_NOR = 5;
    localparam int ALU_OR = 6, ALU_XOR = 7, ALU_SLL = 8, ALU_SRL = 9, ALU_SRA = 10, ALU_LUI = 11;
    localparam logic [2:0] S1_RS   = 3'b001;
    localparam logic [2:0] S1_PC   = 3'b010;
    localparam logic [2:0] S1_SA   = 3'b100;
    localparam logic [3:0] S2_RT   = 4'b0001;
    localparam logic [3:0] S2_SEXT = 4'b0010;
    localparam logic [3:0] S2_ZEXT = 4'b0100;
    localparam logic [3:0] S2_C8   = 4'b1000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1_sel;
        logic [3:0]  src2_sel;
        logic        mem_en;
        logic [3:0]  mem_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        mem_to_rf;
        logic [31:0] opnd1;
        logic [31:0] opnd2;
    } id_ex_t;
    localparam int ID_EX_WD = $bits(id_ex_t);
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction
endpackage

// File: rtl/id_stage_fwd_if.sv
// id_stage_fwd_if: IF/ID/EX handshake, regfile read and forwarding bus of the decode stage.
interface id_stage_fwd_if import id_stage_fwd_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NFWD = 3
) ();
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_pc;
    logic [31:0]          in_inst;
    logic [4:0]           rf_raddr1;
    logic [4:0]           rf_raddr2;
    logic [XLEN-1:0]      rf_rdata1;
    logic [XLEN-1:0]      rf_rdata2;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD-1:0]      fwd_is_load;
    logic [NFWD*5-1:0]    fwd_waddr;
    logic [NFWD*XLEN-1:0] fwd_wdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [ID_EX_WD-1:0]  out_bus;
    logic                 br_valid;
    logic [XLEN-1:0]      br_target;
    logic                 stall_req;
    modport master (
        output flush, in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
               fwd_we, fwd_is_load, fwd_waddr, fwd_wdata, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_bus, br_valid, br_target, stall_req
    );
    modport slave (
        input  flush, in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
               fwd_we, fwd_is_load, fwd_waddr, fwd_wdata, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_bus, br_valid, br_target, stall_req
    );
endinterface

// File: rtl/id_stage_fwd_fwd_mux.sv
// id_fwd_mux: priority operand forwarding (lowest index wins) with a pending-load hit flag.
module id_fwd_mux import id_stage_fwd_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NFWD = 3
) (
    input  logic [4:0]           addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_is_load,
    input  logic [NFWD*5-1:0]    fwd_waddr,
    input  logic [NFWD*XLEN-1:0] fwd_wdata,
    output logic [XLEN-1:0]      data,
    output logic                 load_hit
);
    // Walk from lowest to highest priority so the last match written wins.
    always_comb begin
        data = rf_data;
        load_hit = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_waddr[i*5 +: 5] == addr) begin
                data = fwd_wdata[i*XLEN +: XLEN];
                load_hit = fwd_is_load[i] && (i < FWD_WB);
            end
        end
        if (addr == 5'd0) begin
            data = '0;
            load_hit = 1'b0;
        end
    end
endmodule

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: MIPS-subset decode stage with forwarding, load-use interlock and branch resolution.
module id_stage_fwd import id_stage_fwd_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NFWD = 3
) (
    input logic          clk,
    input logic          rst_n,
    id_stage_fwd_if.slave bus
);
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            fire, accept, hit1, hit2, stall;
    logic [XLEN-1:0] opnd1, opnd2, pc4;
    logic [11:0]     alu;
    id_ex_t          ob;

    wire [5:0] op    = inst[31:26];
    wire [5:0] funct = inst[5:0];
    wire [4:0] rs    = inst[25:21];
    wire [4:0] rt    = inst[20:16];
    wire [4:0] rd    = inst[15:11];

    wire is_sp    = op == OP_SPECIAL;
    wire is_ri    = op == OP_REGIMM;
    wire d_addu   = is_sp && funct == F_ADDU;
    wire d_subu   = is_sp && funct == F_SUBU;
    wire d_and    = is_sp && funct == F_AND;
    wire d_or     = is_sp && funct == F_OR;
    wire d_slt    = is_sp && funct == F_SLT;
    wire d_jr     = is_sp && funct == F_JR;
    wire d_jalr   = is_sp && funct == F_JALR;
    wire d_addiu  = op == OP_ADDIU;
    wire d_ori    = op == OP_ORI;
    wire d_lui    = op == OP_LUI;
    wire d_lw     = op == OP_LW;
    wire d_sw     = op == OP_SW;
    wire d_beq    = op == OP_BEQ;
    wire d_bne    = op == OP_BNE;
    wire d_blez   = op == OP_BLEZ;
    wire d_bgtz   = op == OP_BGTZ;
    wire d_j      = op == OP_J;
    wire d_jal    = op == OP_JAL;
    wire d_bltz   = is_ri && rt == RI_BLTZ;
    wire d_bgez   = is_ri && rt == RI_BGEZ;
    wire d_bltzal = is_ri && rt == RI_BLTZAL;
    wire d_bgezal = is_ri && rt == RI_BGEZAL;

    wire link    = d_jal || d_jalr || d_bltzal || d_bgezal;
    wire rt_dest = d_addiu || d_ori || d_lui || d_lw;
    wire rd_dest = d_addu || d_subu || d_and || d_or || d_slt || d_jalr;
    wire r31     = d_jal || d_bltzal || d_bgezal;
    wire [4:0] waddr = r31 ? 5'd31 : rd_dest ? rd : rt;

    wire neg  = opnd1[XLEN-1];
    wire zero = opnd1 == '0;
    wire eq   = opnd1 == opnd2;
    wire taken = (d_beq && eq) || (d_bne && !eq) || ((d_bgez || d_bgezal) && !neg)
              || (d_bgtz && !neg && !zero) || (d_blez && (neg || zero))
              || ((d_bltz || d_bltzal) && neg) || d_j || d_jal || d_jr || d_jalr;

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd1 (
        .addr(rs), .rf_data(bus.rf_rdata1), .fwd_we(bus.fwd_we), .fwd_is_load(bus.fwd_is_load),
        .fwd_waddr(bus.fwd_waddr), .fwd_wdata(bus.fwd_wdata), .data(opnd1), .load_hit(hit1)
    );
    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd2 (
        .addr(rt), .rf_data(bus.rf_rdata2), .fwd_we(bus.fwd_we), .fwd_is_load(bus.fwd_is_load),
        .fwd_waddr(bus.fwd_waddr), .fwd_wdata(bus.fwd_wdata), .data(opnd2), .load_hit(hit2)
    );

    assign stall  = valid && (hit1 || hit2);
    assign fire   = bus.out_valid && bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;
    assign pc4    = pc + 32'd4;

    assign bus.stall_req = stall;
    assign bus.out_valid = valid && !stall && !bus.flush;
    assign bus.in_ready  = !bus.flush && (!valid || fire);
    assign bus.rf_raddr1 = rs;
    assign bus.rf_raddr2 = rt;
    assign bus.br_valid  = fire && taken;
    assign bus.br_target = (d_jr || d_jalr) ? opnd1
                         : (d_j || d_jal) ? {pc4[31:28], inst[25:0], 2'b00}
                         : pc4 + (sext16(inst[15:0]) << 2);

    always_comb begin
        alu = '0;
        alu[ALU_ADD] = d_addiu || d_addu || d_lw || d_sw || link;
        alu[ALU_SUB] = d_subu;
        alu[ALU_SLT] = d_slt;
        alu[ALU_AND] = d_and;
        alu[ALU_OR]  = d_or || d_ori;
        alu[ALU_LUI] = d_lui;
    end

    always_comb begin
        ob.pc        = pc;
        ob.inst      = inst;
        ob.alu_op    = alu;
        ob.src1_sel  = link ? S1_PC : S1_RS;
        ob.src2_sel  = link ? S2_C8 : (d_addiu || d_lw || d_sw) ? S2_SEXT : (d_ori || d_lui) ? S2_ZEXT : S2_RT;
        ob.mem_en    = d_lw || d_sw;
        ob.mem_wen   = d_sw ? 4'hf : 4'h0;
        ob.rf_we     = (rt_dest || rd_dest || r31) && waddr != 5'd0;
        ob.rf_waddr  = waddr;
        ob.mem_to_rf = d_lw;
        ob.opnd1     = opnd1;
        ob.opnd2     = opnd2;
    end
    assign bus.out_bus = ob;

    // flush wins over both a new accept and a concurrent fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (bus.flush) begin
            valid <= 1'b0;
        end else if (accept) begin
            valid <= 1'b1;
            pc    <= bus.in_pc;
            inst  <= bus.in_inst;
        end else if (fire) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_stage_fwd.sv
// tb_id_stage_fwd: directed checks of decode, forwarding, interlock, branches, flush and reset.
module tb_id_stage_fwd;
    import id_stage_fwd_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    id_ex_t ob;

    always #5 clk = ~clk;

    id_stage_fwd_if #(.XLEN(32), .NFWD(3)) bus ();
    id_stage_fwd #(.XLEN(32), .NFWD(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign ob = bus.out_bus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_pc = pc;
        bus.in_inst = inst;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic drain;
        bus.fwd_we = '0;
        bus.fwd_is_load = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0; bus.in_inst = 0;
        bus.rf_rdata1 = 0; bus.rf_rdata2 = 0; bus.fwd_we = 0; bus.fwd_is_load = 0;
        bus.fwd_waddr = 0; bus.fwd_wdata = 0; bus.out_ready = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_br_valid", bus.br_valid, 0);
        chk("rst_stall", bus.stall_req, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_raddr1", bus.rf_raddr1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDIU $2,$0,5
        bus.rf_rdata1 = 32'h55; bus.rf_rdata2 = 32'h66;
        load(32'h100, 32'h24020005);
        chk("addiu_out_valid", bus.out_valid, 1);
        chk("addiu_waddr", ob.rf_waddr, 2);
        chk("addiu_we", ob.rf_we, 1);
        chk("addiu_opnd1_r0", ob.opnd1, 0);
        chk("addiu_br_valid", bus.br_valid, 0);
        chk("addiu_in_ready_held", bus.in_ready, 0);
        chk("addiu_alu", ob.alu_op, 32'h001);
        chk("addiu_src2", ob.src2_sel, 4'b0010);
        chk("addiu_raddr2", bus.rf_raddr2, 2);
        chk("addiu_pc", ob.pc, 32'h100);
        drain();

        // ADDU $3,$2,$2 with EX and WB both matching
        load(32'h104, 32'h00421821);
        bus.fwd_waddr = {5'd2, 5'd0, 5'd2};
        bus.fwd_wdata = {32'd9, 32'd0, 32'd7};
        bus.fwd_we = 3'b101;
        #1;
        chk("fwd_ex_opnd1", ob.opnd1, 7);
        chk("fwd_ex_opnd2", ob.opnd2, 7);
        chk("addu_waddr", ob.rf_waddr, 3);
        bus.fwd_we = 3'b100;
        #1;
        chk("fwd_wb_opnd1", ob.opnd1, 9);
        bus.fwd_we = 3'b000; bus.rf_rdata1 = 32'h11;
        #1;
        chk("fwd_none_opnd1", ob.opnd1, 32'h11);
        drain();

        // Load-use: ADDU $5,$4,$0 with load walking EX -> MEM -> WB
        load(32'h108, 32'h00802821);
        bus.fwd_we = 3'b001; bus.fwd_is_load = 3'b001;
        bus.fwd_waddr = {5'd0, 5'd0, 5'd4};
        bus.fwd_wdata = {32'hBEEF, 32'h0, 32'hDEAD};
        bus.out_ready = 1'b1;
        #1;
        chk("lu_ex_stall", bus.stall_req, 1);
        chk("lu_ex_out_valid", bus.out_valid, 0);
        chk("lu_ex_in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.fwd_we = 3'b010; bus.fwd_is_load = 3'b010; bus.fwd_waddr = {5'd0, 5'd4, 5'd0};
        #1;
        chk("lu_mem_stall", bus.stall_req, 1);
        @(negedge clk);
        bus.fwd_we = 3'b100; bus.fwd_is_load = 3'b100; bus.fwd_waddr = {5'd4, 5'd0, 5'd0};
        #1;
        chk("lu_wb_stall", bus.stall_req, 0);
        chk("lu_wb_out_valid", bus.out_valid, 1);
        chk("lu_wb_opnd1", ob.opnd1, 32'hBEEF);
        drain();

        // BEQ taken, held two cycles before firing
        bus.rf_rdata1 = 32'h42; bus.rf_rdata2 = 32'h42;
        load(32'h1000, 32'h10220003);
        chk("beq_target", bus.br_target, 32'h1010);
        chk("beq_hold1_br", bus.br_valid, 0);
        chk("beq_out_valid", bus.out_valid, 1);
        @(negedge clk); #1;
        chk("beq_hold2_br", bus.br_valid, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("beq_fire_br", bus.br_valid, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("beq_after_br", bus.br_valid, 0);
        chk("beq_after_valid", bus.out_valid, 0);

        // BNE with equal operands: not taken
        load(32'h1010, 32'h14220003);
        bus.out_ready = 1'b1;
        #1;
        chk("bne_not_taken", bus.br_valid, 0);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // BLEZ on zero, negative offset
        bus.rf_rdata1 = 32'h0;
        load(32'h2000, 32'h1820FFFF);
        bus.out_ready = 1'b1;
        #1;
        chk("blez_zero_taken", bus.br_valid, 1);
        chk("blez_target", bus.br_target, 32'h2000);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // JALR $31,$8
        bus.rf_rdata1 = 32'h2000;
        load(32'h3000, 32'h0100F809);
        bus.out_ready = 1'b1;
        #1;
        chk("jalr_target", bus.br_target, 32'h2000);
        chk("jalr_waddr", ob.rf_waddr, 31);
        chk("jalr_we", ob.rf_we, 1);
        chk("jalr_src1_pc", ob.src1_sel, 3'b010);
        chk("jalr_src2_c8", ob.src2_sel, 4'b1000);
        chk("jalr_alu_add", ob.alu_op, 32'h001);
        chk("jalr_pc", ob.pc, 32'h3000);
        chk("jalr_br_valid", bus.br_valid, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // J at top region keeps pc+4 upper nibble
        load(32'hF0000000, 32'h0BFFFFFF);
        chk("j_target", bus.br_target, 32'hFFFFFFFC);
        chk("j_we", ob.rf_we, 0);
        drain();

        // SW / LW $0 / unknown opcode
        load(32'h4000, 32'hAC850008);
        chk("sw_mem_en", ob.mem_en, 1);
        chk("sw_wen", ob.mem_wen, 4'hf);
        chk("sw_we", ob.rf_we, 0);
        drain();
        load(32'h4004, 32'h8C200000);
        chk("lw_r0_we", ob.rf_we, 0);
        chk("lw_mem_to_rf", ob.mem_to_rf, 1);
        drain();
        load(32'h4008, 32'hFC000000);
        bus.out_ready = 1'b1;
        #1;
        chk("nop_we", ob.rf_we, 0);
        chk("nop_mem_en", ob.mem_en, 0);
        chk("nop_br", bus.br_valid, 0);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // flush concurrent with a new offer
        load(32'h5000, 32'h24020005);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h5004; bus.in_inst = 32'h24030009;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("flush_valid_cleared", bus.out_valid, 0);
        chk("flush_in_ready_after", bus.in_ready, 1);
        chk("flush_not_captured", bus.rf_raddr2, 2);

        // reset asserted mid-stall
        load(32'h6000, 32'h00802821);
        bus.fwd_we = 3'b001; bus.fwd_is_load = 3'b001; bus.fwd_waddr = {5'd0, 5'd0, 5'd4};
        bus.out_ready = 1'b1;
        #1;
        chk("rs_stall_before", bus.stall_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_stall_async", bus.stall_req, 0);
        chk("rs_out_valid_async", bus.out_valid, 0);
        chk("rs_in_ready_async", bus.in_ready, 1);
        chk("rs_raddr1_async", bus.rf_raddr1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.fwd_we = '0; bus.fwd_is_load = '0;
        #1;
        chk("rs_release_out_valid", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
